inst_rom_resp: RTL and testbench

- Instruction-memory responder on the fetch interface; the fetch stage drives `ce` and `pc` into it.
- Returns the 32-bit instruction word combinationally so the single-cycle datapath closes in one clock.
- Contains a sequential byte-stream boot loader that fills the word array before the CPU runs.
- Flags misaligned and out-of-range fetches to the exception logic.

---
 rtl/inst_rom_resp.sv | 155 +++++++++++++++
 tb/tb_inst_rom_resp.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_rom_resp.sv
// inst_rom_resp: combinational instruction memory on the fetch interface, filled by a byte-stream boot loader.
// Define INST_ROM_PARITY_EN to store an even-parity bit with each word and expose parity_err.
module inst_rom_resp #(
   parameter int unsigned AW        = 10,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter logic [31:0] NOP_WORD  = 32'h0000_0000
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ce,
   input  logic [31:0]   pc,
   output logic [31:0]   inst,
   output logic          inst_valid,
   output logic          fetch_fault,
   input  logic          boot,
   input  logic          ld_valid,
   input  logic [7:0]    ld_byte,
   output logic          ld_ready,
   output logic          ld_done,
   output logic [AW:0]   ld_words
`ifdef INST_ROM_PARITY_EN
   ,
   output logic          parity_err
`endif
);

   localparam int unsigned DEPTH = 1 << AW;
   localparam logic [31:0] SPAN  = 32'(DEPTH) << 2;
`ifdef INST_ROM_PARITY_EN
   localparam int unsigned MW = 33;
`else
   localparam int unsigned MW = 32;
`endif

   typedef enum logic [1:0] {RUN, LOAD, DRAIN} state_t;

   state_t        state_q, state_d;
   logic [1:0]    cnt_q, cnt_d;
   logic [31:0]   asm_q, asm_d;
   logic [AW:0]   words_q, words_d;
   logic          done_q, done_d;

   logic          we;
   logic [31:0]   wdata;
   logic [MW-1:0] wword;
   logic [MW-1:0] mem_q [DEPTH];
   logic [MW-1:0] rword;

   logic [31:0]   off;
   logic          misaligned;
   logic          oor;
   logic          active;

   assign ld_ready = (state_q == LOAD) && !words_q[AW];
   assign ld_done  = done_q;
   assign ld_words = words_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      asm_d   = asm_q;
      words_d = words_q;
      done_d  = 1'b0;
      we      = 1'b0;
      wdata   = asm_q;
      unique case (state_q)
         RUN: begin
            if (boot) begin
               state_d = LOAD;
               cnt_d   = '0;
               asm_d   = '0;
               words_d = '0;
            end
         end
         LOAD: begin
            if (ld_valid && ld_ready) begin
               if (cnt_q == 2'd3) begin
                  we      = 1'b1;
                  wdata   = {ld_byte, asm_q[23:0]};
                  words_d = words_q + 1'b1;
                  cnt_d   = '0;
                  asm_d   = '0;
               end else begin
                  asm_d[{cnt_q, 3'b000} +: 8] = ld_byte;
                  cnt_d = cnt_q + 2'd1;
               end
            end
            // A byte accepted on the cycle boot falls still counts toward the drain decision.
            if (!boot) begin
               if (cnt_d != 2'd0) begin
                  state_d = DRAIN;
               end else begin
                  state_d = RUN;
                  done_d  = 1'b1;
               end
            end
         end
         DRAIN: begin
            we      = 1'b1;
            wdata   = asm_q;
            words_d = words_q + 1'b1;
            cnt_d   = '0;
            asm_d   = '0;
            state_d = RUN;
            done_d  = 1'b1;
         end
         default: state_d = RUN;
      endcase
   end

`ifdef INST_ROM_PARITY_EN
   assign wword = {^wdata, wdata};
`else
   assign wword = wdata;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         cnt_q   <= '0;
         asm_q   <= '0;
         words_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         asm_q   <= asm_d;
         words_q <= words_d;
         done_q  <= done_d;
      end
   end

   always_ff @(posedge clk) begin
      if (we && !rst) begin
         mem_q[words_q[AW-1:0]] <= wword;
      end
   end

   // Offset comparison covers pc below BASE_ADDR through unsigned wrap.
   always_comb begin
      off         = pc - BASE_ADDR;
      misaligned  = (pc[1:0] != 2'b00);
      oor         = (off >= SPAN);
      active      = ce && (state_q == RUN);
      fetch_fault = active && (misaligned || oor);
      inst_valid  = active && !misaligned && !oor;
      rword       = mem_q[off[AW+1:2]];
      inst        = inst_valid ? rword[31:0] : NOP_WORD;
   end

`ifdef INST_ROM_PARITY_EN
   assign parity_err = inst_valid && (rword[32] != ^rword[31:0]);
`endif

endmodule

// File: tb/tb_inst_rom_resp.sv
// tb_inst_rom_resp: scoreboard bench for inst_rom_resp; loader sessions push expected words, fetches pop and compare.
module tb_inst_rom_resp;

   localparam int unsigned AW    = 4;
   localparam int unsigned DEPTH = 1 << AW;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic          clk = 1'b0;
   logic          rst;
   logic          ce;
   logic [31:0]   pc;
   logic [31:0]   inst;
   logic          inst_valid;
   logic          fetch_fault;
   logic          boot;
   logic          ld_valid;
   logic [7:0]    ld_byte;
   logic          ld_ready;
   logic          ld_done;
   logic [AW:0]   ld_words;
`ifdef INST_ROM_PARITY_EN
   logic          parity_err;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } exp_t;

   exp_t          sb[$];
   logic [31:0]   exp_mem [DEPTH];
   logic [31:0]   asm_m;
   int unsigned   cnt_m;
   int unsigned   words_m;

   inst_rom_resp #(
      .AW        (AW),
      .BASE_ADDR (32'h0000_0000),
      .NOP_WORD  (NOP)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .ce          (ce),
      .pc          (pc),
      .inst        (inst),
      .inst_valid  (inst_valid),
      .fetch_fault (fetch_fault),
      .boot        (boot),
      .ld_valid    (ld_valid),
      .ld_byte     (ld_byte),
      .ld_ready    (ld_ready),
      .ld_done     (ld_done),
      .ld_words    (ld_words)
`ifdef INST_ROM_PARITY_EN
      ,
      .parity_err  (parity_err)
`endif
   );

   always #5 clk = ~clk;

   task automatic start_session();
      @(negedge clk);
      boot     = 1'b1;
      ld_valid = 1'b0;
      asm_m    = '0;
      cnt_m    = 0;
      words_m  = 0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      ld_valid = 1'b1;
      ld_byte  = b;
      if (words_m < DEPTH) begin
         asm_m[8*cnt_m +: 8] = b;
         cnt_m++;
         if (cnt_m == 4) begin
            exp_mem[words_m] = asm_m;
            sb.push_back('{32'(words_m * 4), asm_m});
            words_m++;
            cnt_m = 0;
            asm_m = '0;
         end
      end
   endtask

   task automatic end_session();
      @(negedge clk);
      ld_valid = 1'b0;
      boot     = 1'b0;
      if (cnt_m != 0) begin
         exp_mem[words_m] = asm_m;
         sb.push_back('{32'(words_m * 4), asm_m});
         words_m++;
         cnt_m = 0;
         asm_m = '0;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; boot = 1'b1; ld_valid = 1'b1; ld_byte = 8'h55; ce = 1'b0; pc = '0;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (ld_ready !== 1'b0 || ld_done !== 1'b0 || ld_words !== '0) begin
         errors++;
         $display("FAIL reset_outputs ready=%b done=%b words=%0d expected 0 0 0", ld_ready, ld_done, ld_words);
      end
      @(negedge clk);
      rst = 1'b0; boot = 1'b0; ld_valid = 1'b0;
      @(negedge clk);
      ce = 1'b1; pc = 32'h0;
      #1;
      checks++;
      if (inst_valid !== 1'b1 || fetch_fault !== 1'b0) begin
         errors++;
         $display("FAIL reset_fetch valid=%b fault=%b expected 1 0", inst_valid, fetch_fault);
      end
   endtask

   task automatic test_load();
      int lat;
      int pulses;
      exp_t e;
      logic [7:0] bytes [8] = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
      ce = 1'b1; pc = 32'h2;
      start_session();
      @(negedge clk);
      #1;
      checks++;
      if (ld_ready !== 1'b1 || inst_valid !== 1'b0 || fetch_fault !== 1'b0) begin
         errors++;
         $display("FAIL load_state ready=%b valid=%b fault=%b expected 1 0 0", ld_ready, inst_valid, fetch_fault);
      end
      for (int i = 0; i < 8; i++) send_byte(bytes[i]);
      end_session();
      lat = 0; pulses = 0;
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk); #1;
         if (ld_done === 1'b1) begin
            pulses++;
            if (lat == 0) lat = i;
         end
      end
      checks++;
      if (lat != 1 || pulses != 1) begin
         errors++;
         $display("FAIL load_done latency=%0d pulses=%0d expected 1 1", lat, pulses);
      end
      checks++;
      if (ld_words !== words_m[AW:0]) begin
         errors++;
         $display("FAIL load_words got=%0d expected %0d", ld_words, words_m);
      end
      while (sb.size() > 0) begin
         e = sb.pop_front();
         @(negedge clk); pc = e.addr; #1;
         checks++;
         if (inst_valid !== 1'b1 || inst !== e.data) begin
            errors++;
            $display("FAIL load_fetch pc=%h inst=%h valid=%b expected %h valid 1", e.addr, inst, inst_valid, e.data);
         end
      end
   endtask

   task automatic test_drain();
      int lat;
      int pulses;
      exp_t e;
      ce = 1'b1; pc = 32'h2;
      start_session();
      send_byte(8'hAA);
      send_byte(8'hBB);
      end_session();
      lat = 0; pulses = 0;
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk); #1;
         if (i == 1) begin
            checks++;
            if (inst_valid !== 1'b0 || fetch_fault !== 1'b0 || ld_done !== 1'b0) begin
               errors++;
               $display("FAIL drain_state valid=%b fault=%b done=%b expected 0 0 0", inst_valid, fetch_fault, ld_done);
            end
         end
         if (ld_done === 1'b1) begin
            pulses++;
            if (lat == 0) lat = i;
         end
      end
      checks++;
      if (lat != 2 || pulses != 1) begin
         errors++;
         $display("FAIL drain_done latency=%0d pulses=%0d expected 2 1", lat, pulses);
      end
      checks++;
      if (ld_words !== words_m[AW:0]) begin
         errors++;
         $display("FAIL drain_words got=%0d expected %0d", ld_words, words_m);
      end
      while (sb.size() > 0) begin
         e = sb.pop_front();
         @(negedge clk); pc = e.addr; #1;
         checks++;
         if (inst_valid !== 1'b1 || inst !== e.data) begin
            errors++;
            $display("FAIL drain_fetch pc=%h inst=%h valid=%b expected %h valid 1", e.addr, inst, inst_valid, e.data);
         end
      end
   endtask

   task automatic test_fetch_faults();
      logic        v_ce    [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      logic [31:0] v_pc    [6] = '{32'h2, 32'(DEPTH * 4), 32'hFFFF_FFFC, 32'h1, 32'h0, 32'h4};
      logic        v_valid [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      logic        v_fault [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      logic [31:0] want;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         ce = v_ce[i]; pc = v_pc[i];
         #1;
         want = v_valid[i] ? exp_mem[v_pc[i][AW+1:2]] : NOP;
         checks++;
         if (inst_valid !== v_valid[i] || fetch_fault !== v_fault[i] || inst !== want) begin
            errors++;
            $display("FAIL fetch_vec%0d pc=%h ce=%b valid=%b fault=%b inst=%h expected %b %b %h",
                     i, v_pc[i], v_ce[i], inst_valid, fetch_fault, inst, v_valid[i], v_fault[i], want);
         end
      end
   endtask

   task automatic test_reset_mid_load();
      int pulses;
      exp_t e;
      logic [7:0] bytes [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      ce = 1'b1; pc = 32'h0;
      start_session();
      for (int i = 0; i < 6; i++) send_byte(bytes[i]);
      @(negedge clk);
      rst = 1'b1; ld_valid = 1'b0; boot = 1'b0;
      cnt_m = 0; asm_m = '0; words_m = 0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (inst_valid !== 1'b1 || ld_words !== '0 || ld_ready !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_state valid=%b words=%0d ready=%b expected 1 0 0", inst_valid, ld_words, ld_ready);
      end
      pulses = (ld_done === 1'b1) ? 1 : 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); #1;
         if (ld_done === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 0) begin
         errors++;
         $display("FAIL rst_mid_done pulses=%0d expected 0", pulses);
      end
      sb.push_back('{32'h4, exp_mem[1]});
      while (sb.size() > 0) begin
         e = sb.pop_front();
         @(negedge clk); pc = e.addr; #1;
         checks++;
         if (inst_valid !== 1'b1 || inst !== e.data) begin
            errors++;
            $display("FAIL rst_mid_fetch pc=%h inst=%h valid=%b expected %h valid 1", e.addr, inst, inst_valid, e.data);
         end
      end
   endtask

   task automatic test_fill();
      int lat;
      int pulses;
      exp_t e;
      ce = 1'b1; pc = 32'h0;
      start_session();
      for (int i = 0; i < int'(DEPTH * 4); i++) send_byte(8'($urandom_range(0, 255)));
      for (int i = 0; i < 4; i++) begin
         send_byte(8'($urandom_range(0, 255)));
         #1;
         checks++;
         if (ld_ready !== 1'b0 || ld_words !== 5'(DEPTH)) begin
            errors++;
            $display("FAIL fill_full ready=%b words=%0d expected 0 %0d", ld_ready, ld_words, DEPTH);
         end
      end
      end_session();
      lat = 0; pulses = 0;
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk); #1;
         if (ld_done === 1'b1) begin
            pulses++;
            if (lat == 0) lat = i;
         end
      end
      checks++;
      if (lat != 1 || pulses != 1) begin
         errors++;
         $display("FAIL fill_done latency=%0d pulses=%0d expected 1 1", lat, pulses);
      end
      while (sb.size() > 0) begin
         e = sb.pop_front();
         @(negedge clk); pc = e.addr; #1;
         checks++;
         if (inst_valid !== 1'b1 || inst !== e.data || fetch_fault !== 1'b0) begin
            errors++;
            $display("FAIL fill_fetch pc=%h inst=%h valid=%b fault=%b expected %h valid 1", e.addr, inst, inst_valid, fetch_fault, e.data);
         end
      end
   endtask

`ifdef INST_ROM_PARITY_EN
   task automatic test_parity();
      @(negedge clk);
      ce = 1'b1; pc = 32'h4;
      #1;
      checks++;
      if (parity_err !== 1'b0) begin
         errors++;
         $display("FAIL parity_clean_before err=%b expected 0", parity_err);
      end
      dut.mem_q[0][32] = ~dut.mem_q[0][32];
      @(negedge clk);
      pc = 32'h0;
      #1;
      checks++;
      if (parity_err !== 1'b1 || inst !== exp_mem[0]) begin
         errors++;
         $display("FAIL parity_flip err=%b inst=%h expected 1 %h", parity_err, inst, exp_mem[0]);
      end
      @(negedge clk);
      pc = 32'h8;
      #1;
      checks++;
      if (parity_err !== 1'b0) begin
         errors++;
         $display("FAIL parity_clean_after err=%b expected 0", parity_err);
      end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_load();
      test_drain();
      test_fetch_faults();
      test_reset_mid_load();
      test_fill();
`ifdef INST_ROM_PARITY_EN
      test_parity();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
